// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART (8N1, or 8E1 with UART_RX_PARITY_EN) two-byte command receiver for the FSM/ALU core.
// Latency: cmd_valid rises one cycle after the operand byte's stop-bit sample.
// Backpressure: a command is held until cmd_ready; a command completing while one is pending is dropped and sets sticky overrun.
//
// Parameters: CLKS_PER_BIT (>= 4) clocks per UART bit; HDR_MARK value required in header byte [7:3].
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   rx                - asynchronous UART line, idle high
//   cmd_valid/ready   - command handshake; a/b/opcode stable while cmd_valid
//   a, b, opcode      - operand byte [7:4], operand byte [3:0], header byte [2:0]
//   frame_err         - one-cycle pulse: bad stop bit, bad header marker or bad parity
//   overrun           - sticky until reset: command lost because the previous one was not yet taken
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit after D7.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter logic [4:0]  HDR_MARK     = 5'b10100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] opcode,
  output logic       frame_err,
  output logic       overrun
);

  // Baud counter only ever holds 0 .. CLKS_PER_BIT-1.
  localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer; idles high so reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_m;
  logic rx_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-level receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_PARITY,
    BIT_STOP
  } bit_state_t;

  bit_state_t    bit_state;
  bit_state_t    bit_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_done;
  logic          data_smp;
  logic          stop_smp;
  logic          stop_ok;
  logic          byte_vld;
  logic          byte_err;
`ifdef UART_RX_PARITY_EN
  logic          par_smp;
  logic          par_ok;
`endif

  always_comb begin
    bit_next  = bit_state;
    baud_done = 1'b0;
    data_smp  = 1'b0;
    stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    case (bit_state)
      BIT_IDLE: begin
        if (!rx_s) bit_next = BIT_START;
      end
      BIT_START: begin
        // Mid start bit: a high line here is a glitch, not a frame.
        baud_done = (baud_cnt == HALF_M1);
        if (baud_done) bit_next = rx_s ? BIT_IDLE : BIT_DATA;
      end
      BIT_DATA: begin
        baud_done = (baud_cnt == FULL_M1);
        data_smp  = baud_done;
        if (baud_done && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          bit_next = BIT_PARITY;
`else
          bit_next = BIT_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      BIT_PARITY: begin
        baud_done = (baud_cnt == FULL_M1);
        par_smp   = baud_done;
        if (baud_done) bit_next = BIT_STOP;
      end
`endif
      BIT_STOP: begin
        // Leave at mid stop bit so a directly following start bit is caught.
        baud_done = (baud_cnt == FULL_M1);
        stop_smp  = baud_done;
        if (baud_done) bit_next = BIT_IDLE;
      end
      default: bit_next = BIT_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Parity result is carried to the stop sample so every byte error reports at one point.
  assign stop_ok = rx_s && par_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      par_ok <= 1'b1;
    end else if (bit_state == BIT_IDLE) begin
      par_ok <= 1'b1;
    end else if (par_smp) begin
      par_ok <= (rx_s == ^shreg);
    end
  end
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_state <= BIT_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      bit_state <= bit_next;
      byte_vld  <= stop_smp && stop_ok;
      byte_err  <= stop_smp && !stop_ok;

      if ((bit_state == BIT_IDLE) || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end

      if (bit_state == BIT_IDLE) begin
        bit_cnt <= '0;
      end else if (data_smp && (bit_cnt != 3'd7)) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      // LSB first. shreg stays untouched until the next frame's data bits,
      // so the assembler can read it directly in the byte_vld cycle.
      if (data_smp) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Byte assembler: header byte, then operand byte
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ASM_HDR,
    ASM_OPS
  } asm_state_t;

  asm_state_t asm_state;
  asm_state_t asm_next;
  logic       hdr_ok;
  logic       hdr_bad;
  logic       cmd_done;
  logic [2:0] opc_pend;
  logic       accept;

  always_comb begin
    asm_next = asm_state;
    hdr_ok   = 1'b0;
    hdr_bad  = 1'b0;
    cmd_done = 1'b0;
    if (byte_err) begin
      asm_next = ASM_HDR;
    end else if (byte_vld) begin
      case (asm_state)
        ASM_HDR: begin
          if (shreg[7:3] == HDR_MARK) begin
            hdr_ok   = 1'b1;
            asm_next = ASM_OPS;
          end else begin
            hdr_bad  = 1'b1;
          end
        end
        ASM_OPS: begin
          cmd_done = 1'b1;
          asm_next = ASM_HDR;
        end
        default: asm_next = ASM_HDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      asm_state <= ASM_HDR;
      opc_pend  <= '0;
      frame_err <= 1'b0;
    end else begin
      asm_state <= asm_next;
      frame_err <= byte_err || hdr_bad;
      if (hdr_ok) opc_pend <= shreg[2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      overrun   <= 1'b0;
    end else if (cmd_done && (!cmd_valid || accept)) begin
      // Slot is free, or frees on this very edge: take the new command.
      cmd_valid <= 1'b1;
      a         <= shreg[7:4];
      b         <= shreg[3:0];
      opcode    <= opc_pend;
    end else begin
      if (cmd_done) overrun   <= 1'b1;
      if (accept)   cmd_valid <= 1'b0;
    end
  end

endmodule
